// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I fetch front end.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013; // addi x0,x0,0

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: PC adder link, redirect input, instruction memory
// handshake and the IF/ID register outputs toward decode.
interface pc_fetch_unit_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_i;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_valid;
    logic [XLEN-1:0] imem_rdata;
    logic            ifid_valid;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_instr;
    logic            ifid_ready;

    // Fetch unit side.
    modport master (
        output pc_o,
        input  pc_plus4_i,
        input  redirect_valid,
        input  redirect_target,
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata,
        output ifid_valid,
        output ifid_pc,
        output ifid_instr,
        input  ifid_ready
    );

    // Environment side: adder, EX stage, instruction memory, decode.
    modport slave (
        input  pc_o,
        output pc_plus4_i,
        output redirect_valid,
        output redirect_target,
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata,
        input  ifid_valid,
        input  ifid_pc,
        input  ifid_instr,
        output ifid_ready
    );

endinterface

// File: rtl/pc_fetch_unit_ifid.sv
// IF/ID pipeline register. Priority: reset > clear > load > consume.
// Clear and consume only drop the valid bit; pc/instr keep their values.
module ifid_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    input  logic            clear,
    input  logic            consume,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    // Register update for the decode-facing slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch sequencer.
//
// state | meaning
// IDLE  | after reset, no request; moves to WAIT next cycle
// WAIT  | request to req_addr_q outstanding
// STALL | response parked in hold buffer, waiting for decode to drain IF/ID
// FLUSH | redirected while a request was in flight; stale response discarded
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_unit_if.master bus
);

    fetch_state_t    state;
    fetch_state_t    next_state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] req_addr_q;
    logic            req_q;
    logic            hold_valid_q;
    logic [XLEN-1:0] hold_pc_q;
    logic [XLEN-1:0] hold_instr_q;

    logic            slot_free;
    logic            load_req_addr;
    logic            ifid_load;
    logic [XLEN-1:0] ifid_load_pc;
    logic [XLEN-1:0] ifid_load_instr;
    logic            ifid_clear;
    logic            hold_load;
    logic            hold_clear;

    assign slot_free = !bus.ifid_valid || bus.ifid_ready;

    // A new request address is latched whenever a fresh request starts in
    // WAIT (entry from another state, or back-to-back after an event).
    assign load_req_addr = (next_state == WAIT) &&
                           ((state != WAIT) || bus.imem_valid || bus.redirect_valid);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, PC update and IF/ID / hold buffer controls.
    always_comb begin
        next_state      = state;
        pc_d            = pc_q;
        ifid_load       = 1'b0;
        ifid_load_pc    = req_addr_q;
        ifid_load_instr = bus.imem_rdata;
        ifid_clear      = 1'b0;
        hold_load       = 1'b0;
        hold_clear      = 1'b0;

        if (bus.redirect_valid) begin
            pc_d       = align_word(bus.redirect_target);
            ifid_clear = 1'b1;
            hold_clear = 1'b1;
            case (state)
                IDLE, STALL: next_state = WAIT;
                WAIT:        next_state = bus.imem_valid ? WAIT : FLUSH;
                FLUSH:       next_state = FLUSH;
                default:     next_state = IDLE;
            endcase
        end else begin
            case (state)
                IDLE: next_state = WAIT;
                WAIT: begin
                    if (bus.imem_valid) begin
                        pc_d = bus.pc_plus4_i;
                        if (slot_free) begin
                            ifid_load = 1'b1;
                        end else begin
                            hold_load  = 1'b1;
                            next_state = STALL;
                        end
                    end
                end
                STALL: begin
                    if (bus.ifid_ready && hold_valid_q) begin
                        ifid_load       = 1'b1;
                        ifid_load_pc    = hold_pc_q;
                        ifid_load_instr = hold_instr_q;
                        hold_clear      = 1'b1;
                        next_state      = WAIT;
                    end
                end
                FLUSH: begin
                    if (bus.imem_valid) begin
                        next_state = WAIT;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // PC, request address/strobe and hold buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            req_q        <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= '0;
            hold_instr_q <= NOP_INSTR;
        end else begin
            pc_q  <= pc_d;
            req_q <= (next_state == WAIT) || (next_state == FLUSH);
            if (load_req_addr) begin
                req_addr_q <= pc_d;
            end
            if (hold_clear) begin
                hold_valid_q <= 1'b0;
            end else if (hold_load) begin
                hold_valid_q <= 1'b1;
                hold_pc_q    <= req_addr_q;
                hold_instr_q <= bus.imem_rdata;
            end
        end
    end

    assign bus.pc_o      = pc_q;
    assign bus.imem_req  = req_q;
    assign bus.imem_addr = req_addr_q;

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk        (clk),
        .rst        (rst),
        .load       (ifid_load),
        .load_pc    (ifid_load_pc),
        .load_instr (ifid_load_instr),
        .clear      (ifid_clear),
        .consume    (bus.ifid_ready),
        .valid      (bus.ifid_valid),
        .pc         (bus.ifid_pc),
        .instr      (bus.ifid_instr)
    );

endmodule
